// File: rtl/solution_capture_fifo_pkg.sv
// -----------------------------------------------------------------------------
// solution_pkg
// Shared constants and types for the solution capture FIFO.
//   DATA_W          : width of one candidate word from the difficulty filter
//   BEAT_W          : width of one readout beat
//   BEATS_PER_ENTRY : beats drained per FIFO entry (4 data beats, plus one
//                     leading timestamp beat when SOLUTION_TIMESTAMP_EN is set)
//   ENTRY_W         : stored entry width (timestamp, if any, in the low word)
//   state_e         : readout FSM states
// Optional feature macro: SOLUTION_TIMESTAMP_EN
// -----------------------------------------------------------------------------
package solution_pkg;

    localparam int DATA_W = 128;
    localparam int BEAT_W = 32;

`ifdef SOLUTION_TIMESTAMP_EN
    localparam int BEATS_PER_ENTRY = 5;
`else
    localparam int BEATS_PER_ENTRY = 4;
`endif

    localparam int ENTRY_W    = BEATS_PER_ENTRY * BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS_PER_ENTRY);
    // Beat mux is sized to a power of two so any beat index value selects
    // a defined slot; unused slots read as zero.
    localparam int BEAT_SLOTS = 1 << BEAT_IDX_W;
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS_PER_ENTRY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/solution_capture_fifo_sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x WIDTH FIFO storage with read/write pointers and an occupancy level.
// The caller only asserts wr_en when not full and rd_en when not empty.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   wr_en      : write wr_data at the write pointer
//   wr_data    : entry to store
//   rd_en      : retire the head entry
//   rd_data    : head entry (storage read at the read pointer)
//   level      : number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 128,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    // Storage carries no reset: the level gates whether any slot is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule

// File: rtl/solution_capture_fifo.sv
// -----------------------------------------------------------------------------
// solution_capture_fifo
// Captures qualifying 128-bit candidates from the difficulty filter into a
// small FIFO and drains each entry as 32-bit beats (LSW first) under a
// valid/ready handshake. Keeps saturating found/dropped counters.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   data_i        : candidate word, bits [7:0] are the difficulty byte
//   data_i_valid  : candidate qualifies (no upstream backpressure)
//   out_data      : current beat
//   out_valid     : beat available
//   out_last      : final beat of the current entry
//   out_ready     : consumer accepts beat when out_valid && out_ready
//   found_count   : candidates written into the FIFO (saturating)
//   drop_count    : candidates lost because the FIFO was full (saturating)
//   fifo_level    : occupied entries
// Optional feature macro: SOLUTION_TIMESTAMP_EN -- a free-running 32-bit
// cycle counter is stored with each entry and drained as a leading beat.
// -----------------------------------------------------------------------------
module solution_capture_fifo
    import solution_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     data_i_valid,
    output logic [BEAT_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         found_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(DEPTH) + 1;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [BEAT_IDX_W-1:0]   r_beat;
    logic [BEAT_IDX_W-1:0]   w_beat_next;
    logic [CNT_W-1:0]        r_found;
    logic [CNT_W-1:0]        r_drop;

    logic [LW-1:0]           w_level;
    logic [ENTRY_W-1:0]      w_entry;
    logic [ENTRY_W-1:0]      w_head;
    logic                    w_full;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_fire;
    logic                    w_pop;
    logic [BEAT_W-1:0]       w_beats [BEAT_SLOTS];

    // Full is judged on the level before the edge, so a retire in the same
    // cycle does not make room for an incoming candidate.
    assign w_full = (w_level == LW'(DEPTH));
    assign w_push = data_i_valid && !w_full;
    assign w_drop = data_i_valid && w_full;
    assign w_fire = out_valid && out_ready;
    assign w_pop  = w_fire && (r_beat == LAST_BEAT);

`ifdef SOLUTION_TIMESTAMP_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Timestamp sits in the low word so it drains as beat 0.
    assign w_entry = {data_i, r_cycle};
`else
    assign w_entry = data_i;
`endif

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_data (w_entry),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .level   (w_level)
    );

    // Split the head entry into beat slots for the output mux.
    for (genvar gi = 0; gi < BEAT_SLOTS; gi++) begin : g_beat
        if (gi < BEATS_PER_ENTRY) begin : g_used
            assign w_beats[gi] = w_head[gi*BEAT_W +: BEAT_W];
        end else begin : g_pad
            assign w_beats[gi] = '0;
        end
    end

    // Readout FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
        end
    end

    // Readout FSM: next state and beat index
    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_level != '0) begin
                    w_state_next = SEND;
                    w_beat_next  = '0;
                end
            end
            SEND: begin
                if (w_fire) begin
                    if (r_beat == LAST_BEAT) begin
                        w_beat_next = '0;
                        // Keep streaming if anything is left after this retire,
                        // including a candidate accepted on the same edge.
                        if ((w_level > LW'(1)) || w_push) begin
                            w_state_next = SEND;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_beat_next = r_beat + BEAT_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_beat_next  = '0;
            end
        endcase
    end

    // Outputs depend only on FSM registers and FIFO storage; the head slot is
    // never overwritten while SEND is active because writes are blocked when full.
    assign out_valid = (r_state == SEND);
    assign out_last  = out_valid && (r_beat == LAST_BEAT);
    assign out_data  = out_valid ? w_beats[r_beat] : '0;

    // Saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_found <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push && (r_found != '1)) begin
                r_found <= r_found + CNT_W'(1);
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_W'(1);
            end
        end
    end

    assign found_count = r_found;
    assign drop_count  = r_drop;
    assign fifo_level  = w_level;

endmodule

// File: tb/tb_solution_capture_fifo.sv
// -----------------------------------------------------------------------------
// tb_solution_capture_fifo
// Directed, self-checking bench for solution_capture_fifo (DEPTH=4, CNT_W=16).
// A cycle-by-cycle vector table covers a single entry and a backpressured
// entry; hand-written sequences cover overflow, push-on-retire and reset
// mid-transfer. With SOLUTION_TIMESTAMP_EN defined, the timestamp beats are
// checked instead.
// -----------------------------------------------------------------------------
module tb_solution_capture_fifo;
    import solution_pkg::*;

    localparam int NB = BEATS_PER_ENTRY;

    logic           clk;
    logic           rst_n;
    logic [127:0]   data_i;
    logic           data_i_valid;
    logic [31:0]    out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic [15:0]    found_count;
    logic [15:0]    drop_count;
    logic [2:0]     fifo_level;

    int n_vec;
    int n_bad;
    int exp_found;
    int exp_drop;

    solution_capture_fifo #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i       (data_i),
        .data_i_valid (data_i_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .found_count  (found_count),
        .drop_count   (drop_count),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [127:0] data;
        logic         ready;
        logic         exp_ov;
        logic         exp_last;
        logic [31:0]  exp_data;
        logic [2:0]   exp_level;
        logic [15:0]  exp_found;
        logic [15:0]  exp_drop;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic v, input logic [127:0] d, input logic r,
                        input logic eov, input logic elast, input logic [31:0] edata,
                        input logic [2:0] elev, input logic [15:0] ef, input logic [15:0] ed);
        vecs[i] = '{v, d, r, eov, elast, edata, elev, ef, ed};
    endtask

    function automatic logic [127:0] mk(input int k);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*32 +: 32] = 32'hC0DE_0000 + 32'(k * 16 + i);
        end
        return r;
    endfunction

    task automatic check_counters(input string tag, input int lvl);
        check({tag, ".level"}, 32'(fifo_level), 32'(lvl));
        check({tag, ".found"}, 32'(found_count), 32'(exp_found));
        check({tag, ".drop"},  32'(drop_count),  32'(exp_drop));
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, ".wait_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Drain one entry with out_ready held high; optionally push a candidate on
    // the same edge that retires the final beat.
    task automatic drain_entry(input string tag, input logic [127:0] exp, input logic [31:0] ts,
                               input bit push_on_last, input logic [127:0] pdata);
        logic [31:0] eb;
        out_ready = 1'b1;
        wait_valid(tag);
        for (int b = 0; b < NB; b++) begin
            if (NB == 5) begin
                eb = (b == 0) ? ts : exp[(b-1)*32 +: 32];
            end else begin
                eb = exp[b*32 +: 32];
            end
            $display("%s beat %0d: data=%h last=%0b", tag, b, out_data, out_last);
            check({tag, ".data"}, out_data, eb);
            check({tag, ".last"}, 32'(out_last), 32'(b == NB - 1));
            if (b == NB - 1 && push_on_last) begin
                data_i_valid = 1'b1;
                data_i       = pdata;
            end
            step();
            data_i_valid = 1'b0;
        end
    endtask

    logic [127:0] d1;
    logic [127:0] d2;

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        exp_found    = 0;
        exp_drop     = 0;
        rst_n        = 1'b0;
        data_i       = '0;
        data_i_valid = 1'b0;
        out_ready    = 1'b0;
        d1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        d2 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.last",  32'(out_last),  32'd0);
        check("rst.data",  out_data,       32'd0);
        check_counters("rst", 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SOLUTION_TIMESTAMP_EN
        // Edge e after reset release captures timestamp e.
        out_ready = 1'b0;
        for (int e = 0; e <= 30; e++) begin
            data_i_valid = (e == 10) || (e == 25);
            data_i       = (e == 10) ? d1 : d2;
            step();
        end
        data_i_valid = 1'b0;
        exp_found    = 2;
        check_counters("ts", 2);
        drain_entry("ts10", d1, 32'd10, 1'b0, '0);
        drain_entry("ts25", d2, 32'd25, 1'b0, '0);
        out_ready = 1'b0;
        step();
        check_counters("ts.end", 0);
`else
        // Single entry, then one entry with ready toggling every cycle.
        setv( 0, 0, '0, 1, 0, 0, 32'h0,        3'd0, 16'd0, 16'd0);
        setv( 1, 1, d1, 1, 0, 0, 32'h0,        3'd1, 16'd1, 16'd0);
        setv( 2, 0, '0, 1, 1, 0, 32'h03020100, 3'd1, 16'd1, 16'd0);
        setv( 3, 0, '0, 1, 1, 0, 32'h07060504, 3'd1, 16'd1, 16'd0);
        setv( 4, 0, '0, 1, 1, 0, 32'h0B0A0908, 3'd1, 16'd1, 16'd0);
        setv( 5, 0, '0, 1, 1, 1, 32'h0F0E0D0C, 3'd1, 16'd1, 16'd0);
        setv( 6, 0, '0, 1, 0, 0, 32'h0,        3'd0, 16'd1, 16'd0);
        setv( 7, 1, d2, 0, 0, 0, 32'h0,        3'd1, 16'd2, 16'd0);
        setv( 8, 0, '0, 0, 1, 0, 32'h13121110, 3'd1, 16'd2, 16'd0);
        setv( 9, 0, '0, 1, 1, 0, 32'h17161514, 3'd1, 16'd2, 16'd0);
        setv(10, 0, '0, 0, 1, 0, 32'h17161514, 3'd1, 16'd2, 16'd0);
        setv(11, 0, '0, 1, 1, 0, 32'h1B1A1918, 3'd1, 16'd2, 16'd0);
        setv(12, 0, '0, 0, 1, 0, 32'h1B1A1918, 3'd1, 16'd2, 16'd0);
        setv(13, 0, '0, 1, 1, 1, 32'h1F1E1D1C, 3'd1, 16'd2, 16'd0);
        setv(14, 0, '0, 0, 1, 1, 32'h1F1E1D1C, 3'd1, 16'd2, 16'd0);
        setv(15, 0, '0, 1, 0, 0, 32'h0,        3'd0, 16'd2, 16'd0);

        for (int i = 0; i < 16; i++) begin
            data_i_valid = vecs[i].valid;
            data_i       = vecs[i].data;
            out_ready    = vecs[i].ready;
            step();
            $display("vec %0d: valid=%0b last=%0b data=%h level=%0d found=%0d drop=%0d",
                     i, out_valid, out_last, out_data, fifo_level, found_count, drop_count);
            check($sformatf("vec%0d.valid", i), 32'(out_valid),   32'(vecs[i].exp_ov));
            check($sformatf("vec%0d.last", i),  32'(out_last),    32'(vecs[i].exp_last));
            check($sformatf("vec%0d.data", i),  out_data,         vecs[i].exp_data);
            check($sformatf("vec%0d.level", i), 32'(fifo_level),  32'(vecs[i].exp_level));
            check($sformatf("vec%0d.found", i), 32'(found_count), 32'(vecs[i].exp_found));
            check($sformatf("vec%0d.drop", i),  32'(drop_count),  32'(vecs[i].exp_drop));
        end
        data_i_valid = 1'b0;
        exp_found    = 2;

        // Overflow: six candidates into four slots with the consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            data_i_valid = 1'b1;
            data_i       = mk(k);
            step();
        end
        data_i_valid = 1'b0;
        exp_found += 4;
        exp_drop  += 2;
        check_counters("ovf", 4);

        // Full FIFO: a push on the retiring edge is still dropped.
        drain_entry("e0", mk(0), 32'd0, 1'b1, mk(99));
        exp_drop++;
        check_counters("retire_full", 3);

        // Level 3: a push on the retiring edge is accepted, level unchanged.
        drain_entry("e1", mk(1), 32'd0, 1'b1, mk(6));
        exp_found++;
        check_counters("retire_l3", 3);

        drain_entry("e2", mk(2), 32'd0, 1'b0, '0);
        drain_entry("e3", mk(3), 32'd0, 1'b0, '0);
        drain_entry("e6", mk(6), 32'd0, 1'b0, '0);
        out_ready = 1'b0;
        step();
        check("drained.valid", 32'(out_valid), 32'd0);
        check_counters("drained", 0);

        // Reset while beat 2 of an entry is presented.
        data_i_valid = 1'b1;
        data_i       = d1;
        step();
        data_i_valid = 1'b0;
        out_ready    = 1'b1;
        wait_valid("rstmid");
        step();
        step();
        check("rstmid.beat2", out_data, 32'h0B0A0908);
        #2;
        rst_n = 1'b0;
        #1;
        exp_found = 0;
        exp_drop  = 0;
        $display("async reset: valid=%0b last=%0b data=%h level=%0d found=%0d drop=%0d",
                 out_valid, out_last, out_data, fifo_level, found_count, drop_count);
        check("rstmid.valid", 32'(out_valid), 32'd0);
        check("rstmid.last",  32'(out_last),  32'd0);
        check("rstmid.data",  out_data,       32'd0);
        check_counters("rstmid", 0);
        @(negedge clk);
        rst_n = 1'b1;
        data_i_valid = 1'b1;
        data_i       = d2;
        step();
        data_i_valid = 1'b0;
        exp_found    = 1;
        check_counters("after_rst", 1);
        drain_entry("after_rst", d2, 32'd0, 1'b0, '0);
        out_ready = 1'b0;
        step();
        check_counters("after_rst.end", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
